// File: rtl/csr_exec_unit.sv
// CSR execute stage: decodes Zicsr ops, ECALL and MRET, owns the machine CSR file, bypasses
// in-flight CSR results and raises a one-cycle PC redirect on trap entry and return.
module csr_exec_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_DEPTH = 2,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [31:0]     issue_inst,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [31:0]     issue_pc,
    input  logic            stall,
    input  logic            flush,
    input  logic            retire,
    input  logic            commit_we,
    input  logic [11:0]     commit_addr,
    input  logic [XLEN-1:0] commit_data,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            wb_csr_we,
    output logic [11:0]     wb_csr_addr,
    output logic [XLEN-1:0] wb_csr_wdata,
    output logic            illegal,
    output logic            redirect,
    output logic [31:0]     redirect_pc
);
    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;
    state_e state_q;

    logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]     mcycle_q, minstret_q;
    logic            chain_v_q [FWD_DEPTH];
    logic [11:0]     chain_a_q [FWD_DEPTH];
    logic [XLEN-1:0] chain_d_q [FWD_DEPTH];

    logic [2:0]      funct3;
    logic [4:0]      rs1_field;
    logic [11:0]     csr_addr;
    logic            is_csr, is_ecall, is_mret, accept, ecall_take, mret_take;
    logic            addr_ok, csr_we;
    logic [XLEN-1:0] operand, file_val, old_val, new_val, mstatus_trap;

    assign funct3     = issue_inst[14:12];
    assign rs1_field  = issue_inst[19:15];
    assign csr_addr   = issue_inst[31:20];
    assign is_csr     = issue_inst[6:0] == 7'h73 && funct3[1:0] != 2'b00;
    assign is_ecall   = issue_inst == 32'h0000_0073;
    assign is_mret    = issue_inst == 32'h3020_0073;
    // Issues arriving while the redirect is in flight are dropped.
    assign accept     = issue_valid && !flush && !stall && state_q == StIdle;
    assign ecall_take = accept && is_ecall;
    assign mret_take  = accept && is_mret;
    assign operand    = funct3[2] ? XLEN'(rs1_field) : issue_rs1;
    assign csr_we     = is_csr && addr_ok && (funct3[1:0] == 2'b01 || rs1_field != 5'd0);

    always_comb begin
        file_val = '0;
        addr_ok  = 1'b1;
        case (csr_addr)
            CsrMstatus:   file_val = mstatus_q;
            CsrMtvec:     file_val = mtvec_q;
            CsrMscratch:  file_val = mscratch_q;
            CsrMepc:      file_val = mepc_q;
            CsrMcause:    file_val = mcause_q;
            CsrMcycle:    file_val = XLEN'(mcycle_q[31:0]);
            CsrMcycleh:   file_val = XLEN'(mcycle_q[63:32]);
            CsrMinstret:  file_val = XLEN'(minstret_q[31:0]);
            CsrMinstreth: file_val = XLEN'(minstret_q[63:32]);
            default:      addr_ok  = 1'b0;
        endcase
    end

    // Entry 0 is the newest, so scan oldest-first and let later hits overwrite.
    always_comb begin
        old_val = file_val;
        for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
            if (chain_v_q[i] && chain_a_q[i] == csr_addr) old_val = chain_d_q[i];
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = operand;
        endcase
    end

    always_comb begin
        mstatus_trap = mstatus_q;
        if (is_ecall) begin
            mstatus_trap[7] = mstatus_q[3];
            mstatus_trap[3] = 1'b0;
        end else begin
            mstatus_trap[3] = mstatus_q[7];
            mstatus_trap[7] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_rd_data   <= '0;
            wb_csr_we    <= 1'b0;
            wb_csr_addr  <= '0;
            wb_csr_wdata <= '0;
            illegal      <= 1'b0;
            for (int i = 0; i < int'(FWD_DEPTH); i++) begin
                chain_v_q[i] <= 1'b0;
                chain_a_q[i] <= '0;
                chain_d_q[i] <= '0;
            end
        end else if (flush) begin
            wb_valid  <= 1'b0;
            wb_csr_we <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < int'(FWD_DEPTH); i++) chain_v_q[i] <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= accept;
            wb_rd_data   <= (accept && is_csr && addr_ok) ? old_val : '0;
            wb_csr_we    <= accept && csr_we;
            wb_csr_addr  <= csr_addr;
            wb_csr_wdata <= new_val;
            illegal      <= accept && is_csr && !addr_ok;
            chain_v_q[0] <= accept && csr_we;
            chain_a_q[0] <= csr_addr;
            chain_d_q[0] <= new_val;
            for (int i = 1; i < int'(FWD_DEPTH); i++) begin
                chain_v_q[i] <= chain_v_q[i-1];
                chain_a_q[i] <= chain_a_q[i-1];
                chain_d_q[i] <= chain_d_q[i-1];
            end
        end
    end

    // Trap updates are assigned after the commit so they win on a shared CSR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= '0;
            mtvec_q    <= XLEN'(MTVEC_RST);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            if (commit_we) begin
                case (commit_addr)
                    CsrMstatus:  mstatus_q  <= commit_data;
                    CsrMtvec:    mtvec_q    <= commit_data;
                    CsrMscratch: mscratch_q <= commit_data;
                    CsrMepc:     mepc_q     <= commit_data;
                    CsrMcause:   mcause_q   <= commit_data;
                    default:     ;
                endcase
            end
            if (ecall_take) begin
                mepc_q    <= XLEN'(issue_pc);
                mcause_q  <= XLEN'(11);
                mstatus_q <= mstatus_trap;
            end else if (mret_take) begin
                mstatus_q <= mstatus_trap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (commit_we && commit_addr == CsrMcycle)         mcycle_q[31:0]  <= commit_data[31:0];
            else if (commit_we && commit_addr == CsrMcycleh)   mcycle_q[63:32] <= commit_data[31:0];
            else                                               mcycle_q        <= mcycle_q + 64'd1;
            if (commit_we && commit_addr == CsrMinstret)       minstret_q[31:0]  <= commit_data[31:0];
            else if (commit_we && commit_addr == CsrMinstreth) minstret_q[63:32] <= commit_data[31:0];
            else if (retire)                                   minstret_q <= minstret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ecall_take) begin
                        state_q     <= StRedirect;
                        redirect    <= 1'b1;
                        redirect_pc <= mtvec_q[31:0] & ~32'h3;
                    end else if (mret_take) begin
                        state_q     <= StRedirect;
                        redirect    <= 1'b1;
                        redirect_pc <= mepc_q[31:0];
                    end else begin
                        redirect    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    redirect <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: a table of back-to-back CSR ops plus hand-written
// sequences for stall/flush, counters, trap entry/return and reset during redirect.
module tb_csr_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_inst = '0;
    logic [31:0] issue_rs1 = '0;
    logic [31:0] issue_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        retire = 1'b0;
    logic        commit_we = 1'b0;
    logic [11:0] commit_addr = '0;
    logic [31:0] commit_data = '0;
    logic        wb_valid, wb_csr_we, illegal, redirect;
    logic [31:0] wb_rd_data, wb_csr_wdata, redirect_pc;
    logic [11:0] wb_csr_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_exec_unit #(.XLEN(32), .FWD_DEPTH(2), .MTVEC_RST(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_inst(issue_inst),
        .issue_rs1(issue_rs1), .issue_pc(issue_pc), .stall(stall), .flush(flush),
        .retire(retire), .commit_we(commit_we), .commit_addr(commit_addr),
        .commit_data(commit_data), .wb_valid(wb_valid), .wb_rd_data(wb_rd_data),
        .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
        .illegal(illegal), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        iv;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic        ev;
        logic [31:0] erd;
        logic        ewe;
        logic [11:0] eaddr;
        logic [31:0] ewd;
        logic        eil;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] r,
                                        input logic [2:0] f3);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] rs1v, input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_inst  = inst;
        issue_rs1   = rs1v;
        issue_pc    = pc;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_inst  = '0;
        issue_rs1   = '0;
    endtask

    task automatic commit(input logic [11:0] a, input logic [31:0] d);
        commit_we   = 1'b1;
        commit_addr = a;
        commit_data = d;
    endtask

    task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        issue(enc(a, 5'd0, 3'b010), 32'h0, 32'h0);
        tick();
        chk(name, wb_rd_data, exp);
        idle();
    endtask

    initial begin
        tbl[0]  = '{1, enc(12'h340, 5'd2, 3'b001), 32'hDEADBEEF, 1, 32'h0, 1, 12'h340, 32'hDEADBEEF, 0};
        tbl[1]  = '{1, enc(12'h340, 5'd0, 3'b010), 32'h0, 1, 32'hDEADBEEF, 0, 12'h340, 32'h0, 0};
        tbl[2]  = '{1, enc(12'h300, 5'd8, 3'b110), 32'h0, 1, 32'h0, 1, 12'h300, 32'h8, 0};
        tbl[3]  = '{1, enc(12'h300, 5'd8, 3'b111), 32'h0, 1, 32'h8, 1, 12'h300, 32'h0, 0};
        tbl[4]  = '{1, enc(12'h300, 5'd0, 3'b010), 32'h0, 1, 32'h0, 0, 12'h300, 32'h0, 0};
        tbl[5]  = '{1, enc(12'h340, 5'd0, 3'b010), 32'h0, 1, 32'h0, 0, 12'h340, 32'h0, 0};
        tbl[6]  = '{1, enc(12'h7FF, 5'd1, 3'b001), 32'h55, 1, 32'h0, 0, 12'h7FF, 32'h0, 1};
        tbl[7]  = '{1, enc(12'h340, 5'd1, 3'b011), 32'hF, 1, 32'h0, 1, 12'h340, 32'h0, 0};
        tbl[8]  = '{0, 32'h0, 32'h0, 0, 32'h0, 0, 12'h0, 32'h0, 0};
        tbl[9]  = '{1, enc(12'h305, 5'h1F, 3'b101), 32'h0, 1, 32'h100, 1, 12'h305, 32'h1F, 0};
        tbl[10] = '{1, enc(12'h305, 5'd3, 3'b010), 32'h60, 1, 32'h1F, 1, 12'h305, 32'h7F, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_rd_data", wb_rd_data, 0);
        chk("rst_csr_we", wb_csr_we, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        rst = 1'b1;

        for (int k = 0; k < 11; k++) begin
            issue_valid = tbl[k].iv;
            issue_inst  = tbl[k].inst;
            issue_rs1   = tbl[k].rs1;
            tick();
            chk($sformatf("v%0d_valid", k), wb_valid, tbl[k].ev);
            chk($sformatf("v%0d_rd", k), wb_rd_data, tbl[k].erd);
            chk($sformatf("v%0d_we", k), wb_csr_we, tbl[k].ewe);
            chk($sformatf("v%0d_illegal", k), illegal, tbl[k].eil);
            if (tbl[k].ev) chk($sformatf("v%0d_addr", k), wb_csr_addr, tbl[k].eaddr);
            if (tbl[k].ewe) chk($sformatf("v%0d_wdata", k), wb_csr_wdata, tbl[k].ewd);
        end
        idle();
        tick();
        tick();

        // Stall holds wb and chain; flush empties the chain.
        issue(enc(12'h340, 5'd2, 3'b001), 32'h5A, 0);
        tick();
        issue(enc(12'h340, 5'd2, 3'b001), 32'h33, 0);
        stall = 1'b1;
        tick();
        chk("stall_valid", wb_valid, 1);
        chk("stall_wdata", wb_csr_wdata, 32'h5A);
        stall = 1'b0;
        tick();
        chk("after_stall_wdata", wb_csr_wdata, 32'h33);
        chk("after_stall_bypass", wb_rd_data, 32'h5A);
        issue(enc(12'h340, 5'd0, 3'b010), 0, 0);
        flush = 1'b1;
        tick();
        chk("flush_valid", wb_valid, 0);
        flush = 1'b0;
        tick();
        chk("flush_chain_cleared", wb_rd_data, 32'h0);
        idle();

        // Counters: carry into mcycleh, commit replaces increment.
        commit(12'hB80, 32'h0);
        tick();
        commit(12'hB00, 32'hFFFF_FFFF);
        tick();
        commit_we = 1'b0;
        read_csr("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        read_csr("mcycle_wrap", 12'hB00, 32'h0);
        read_csr("mcycleh_carry", 12'hB80, 32'h1);
        commit(12'hB00, 32'h5);
        tick();
        commit_we = 1'b0;
        read_csr("mcycle_commit", 12'hB00, 32'h5);
        commit(12'hB02, 32'h0);
        retire = 1'b1;
        tick();
        commit_we = 1'b0;
        tick();
        tick();
        retire = 1'b0;
        read_csr("minstret", 12'hB02, 32'h2);

        // Trap entry and return.
        commit(12'h305, 32'h200);
        tick();
        commit(12'h300, 32'h8);
        tick();
        commit_we = 1'b0;
        issue(32'h0000_0073, 0, 32'h40);
        tick();
        chk("ecall_redirect", redirect, 1);
        chk("ecall_pc", redirect_pc, 32'h200);
        issue(enc(12'h340, 5'd2, 3'b001), 32'h1, 0);
        tick();
        chk("redirect_one_cycle", redirect, 0);
        chk("issue_in_redirect_ignored", wb_valid, 0);
        idle();
        read_csr("mepc", 12'h341, 32'h40);
        read_csr("mcause", 12'h342, 32'd11);
        read_csr("mstatus_trap", 12'h300, 32'h80);
        issue(32'h3020_0073, 0, 0);
        tick();
        chk("mret_redirect", redirect, 1);
        chk("mret_pc", redirect_pc, 32'h40);
        idle();
        tick();
        read_csr("mstatus_mret", 12'h300, 32'h88);

        // Trap beats a commit to mepc; a commit to mscratch in the same cycle proceeds.
        issue(32'h0000_0073, 0, 32'h80);
        commit(12'h341, 32'h999);
        tick();
        chk("ecall2_pc", redirect_pc, 32'h200);
        commit(12'h340, 32'h77);
        idle();
        tick();
        commit_we = 1'b0;
        read_csr("mepc_trap_wins", 12'h341, 32'h80);
        read_csr("mscratch_commit", 12'h340, 32'h77);

        // Asynchronous reset in the middle of a redirect.
        issue(32'h0000_0073, 0, 32'h0);
        tick();
        idle();
        chk("pre_reset_redirect", redirect, 1);
        rst = 1'b0;
        #1;
        chk("async_reset_redirect", redirect, 0);
        chk("async_reset_pc", redirect_pc, 0);
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
